// File: rtl/lr3_pkg.sv
// Shared constants for the lr3 hex-entry display: digit count, glyph table, blank codes.
package lr3_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;

  // Blanked display: all cathodes and anodes inactive (active-low outputs).
  localparam logic [SEG_W-1:0]      CAT_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Active-low segment patterns, CAT[0]=a .. CAT[6]=g; entry k is the glyph for hex value k.
  localparam logic [15:0][SEG_W-1:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/lr3_hex7seg.sv
// Hex digit to active-low seven-segment glyph decoder.
module hex7seg
  import lr3_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  output logic [SEG_W-1:0]   seg
);

  // Table lookup of the glyph for the incoming nibble.
  always_comb begin
    seg = GLYPH[hex];
  end

endmodule

// File: rtl/lr3.sv
// Eight-digit hex entry shift register with a time-multiplexed seven-segment scan.
// Digits that have not been entered since reset are blanked.
module lr3
  import lr3_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = lr3_pkg::NUM_DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BTN_CE,
  input  logic [DIGIT_W-1:0]    DAT_I,
  input  logic                  DISP_CE,
  output logic [SEG_W-1:0]      CAT,
  output logic [NUM_DIGITS-1:0] AN
);

  localparam int unsigned SW = $clog2(NUM_DIGITS);
  localparam int unsigned FW = $clog2(NUM_DIGITS + 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
  logic [FW-1:0]                      fc;
  logic [SW-1:0]                      scan;
  logic [DIGIT_W-1:0]                 cur_digit;
  logic [SEG_W-1:0]                   cur_glyph;
  logic                               cur_valid;

  // Digit shift register: newest entry lands in position 0, oldest falls off the top.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      digits <= '0;
    end else if (BTN_CE) begin
      digits <= {digits[NUM_DIGITS-2:0], DAT_I};
    end
  end

  // Fill count, saturating once every position holds an entered digit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fc <= '0;
    end else if (BTN_CE && (fc != FW'(NUM_DIGITS))) begin
      fc <= fc + FW'(1);
    end
  end

  // Scan index; power-of-two digit count makes the natural wrap the modulo.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scan <= '0;
    end else if (DISP_CE) begin
      scan <= scan + SW'(1);
    end
  end

  // Digit currently selected by the scan and whether it has been entered.
  always_comb begin
    cur_digit = digits[scan];
    cur_valid = (FW'(scan) < fc);
  end

  hex7seg u_hex7seg (
    .hex (cur_digit),
    .seg (cur_glyph)
  );

  // Drive the selected anode and glyph, or blank the display for unfilled positions.
  always_comb begin
    AN  = AN_OFF;
    CAT = CAT_OFF;
    if (cur_valid) begin
      AN  = ~(NUM_DIGITS'(1) << scan);
      CAT = cur_glyph;
    end
  end

endmodule

// File: tb/tb_lr3.sv
// Self-checking bench for lr3: directed scenarios plus randomized entry/scan traffic
// compared against a queue-based model of the entered digits.
module tb_lr3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ce;
  logic [3:0] dat_i;
  logic       disp_ce;
  logic [6:0] cat;
  logic [7:0] an;

  int checks = 0;
  int errors = 0;

  // Model: entered digits, newest first, at most 8 kept; scan position.
  int unsigned q[$];
  int unsigned s_m;

  logic [6:0] glyph_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  lr3 dut (
    .CLK     (clk),
    .RST     (rst),
    .BTN_CE  (btn_ce),
    .DAT_I   (dat_i),
    .DISP_CE (disp_ce),
    .CAT     (cat),
    .AN      (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_an();
    logic [7:0] one;
    one = 8'h01;
    if (s_m < q.size()) return ~(one << s_m);
    return 8'hFF;
  endfunction

  function automatic logic [6:0] exp_cat();
    if (s_m < q.size()) return glyph_ref[q[s_m]];
    return 7'h7F;
  endfunction

  task automatic check_disp(input string tag);
    check({tag, "_an"},  32'(an),  32'(exp_an()));
    check({tag, "_cat"}, 32'(cat), 32'(exp_cat()));
  endtask

  // One clock with the given strobes; model updated at the edge, outputs sampled 1 time unit later.
  task automatic tick(input logic b, input logic [3:0] dv, input logic dc);
    @(negedge clk);
    btn_ce  = b;
    dat_i   = dv;
    disp_ce = dc;
    @(posedge clk);
    if (b) begin
      q.push_front(32'(dv));
      if (q.size() > 8) void'(q.pop_back());
    end
    if (dc) s_m = (s_m + 1) % 8;
    #1;
    btn_ce  = 1'b0;
    disp_ce = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must blank before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    q.delete();
    s_m = 0;
    check_disp("rst");
    check("rst_an_ff", 32'(an), 32'h0000_00FF);
    @(negedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic scan_to(input int unsigned p);
    for (int i = 0; i < 8 && s_m != p; i++) tick(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    logic [3:0] ovf_seq [10];
    logic [3:0] ovf_exp [8];
    ovf_seq = '{4'h2, 4'h3, 4'h8, 4'h0, 4'h3, 4'hB, 4'hA, 4'hD, 4'h9, 4'hF};
    ovf_exp = '{4'hF, 4'h9, 4'hD, 4'hA, 4'hB, 4'h3, 4'h0, 4'h8};

    rst     = 1'b0;
    btn_ce  = 1'b0;
    dat_i   = 4'h0;
    disp_ce = 1'b0;
    s_m     = 0;
    #1;
    check("por_an",  32'(an),  32'h0000_00FF);
    check("por_cat", 32'(cat), 32'h0000_007F);
    @(negedge clk);
    #3 rst = 1'b1;

    // Reset: scanning an empty register keeps the display blank.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'h0, 1'b1);
      check("s1_an", 32'(an), 32'h0000_00FF);
      check_disp("s1");
    end

    // Single entry of 2.
    do_reset();
    tick(1'b1, 4'h2, 1'b0);
    check("s2_an0",  32'(an),  32'h0000_00FE);
    check("s2_cat0", 32'(cat), 32'h0000_0024);
    for (int i = 1; i < 8; i++) begin
      tick(1'b0, 4'h0, 1'b1);
      check("s2_an_blank", 32'(an), 32'h0000_00FF);
    end

    // Two entries: 2 then 3.
    do_reset();
    tick(1'b1, 4'h2, 1'b0);
    tick(1'b1, 4'h3, 1'b0);
    check("s3_cat0", 32'(cat), 32'h0000_0030);
    tick(1'b0, 4'h0, 1'b1);
    check("s3_an1",  32'(an),  32'h0000_00FD);
    check("s3_cat1", 32'(cat), 32'h0000_0024);

    // Overflow: ten entries, the oldest two are lost.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, ovf_seq[i], 1'b0);
      check_disp("s4_entry");
    end
    for (int i = 0; i < 8; i++) begin
      check("s4_digit", 32'(cat), 32'(glyph_ref[ovf_exp[s_m]]));
      check_disp("s4_scan");
      if (s_m == 7) begin
        check("s4_an7",  32'(an),  32'h0000_007F);
        check("s4_cat7", 32'(cat), 32'h0000_0000);
      end
      tick(1'b0, 4'h0, 1'b1);
    end

    // Scan wrap and simultaneous strobes.
    scan_to(0);
    for (int i = 0; i < 8; i++) tick(1'b0, 4'h0, 1'b1);
    check("s5_wrap_an", 32'(an), 32'h0000_00FE);
    tick(1'b1, 4'h5, 1'b1);
    check("s5_sim_an",  32'(an),  32'h0000_00FD);
    check("s5_sim_cat", 32'(cat), 32'(glyph_ref[4'hF]));
    scan_to(0);
    check("s5_sim_new", 32'(cat), 32'(glyph_ref[4'h5]));

    // Mid-run reset after five entries.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 4'(i + 6), 1'b1);
    do_reset();
    tick(1'b1, 4'h4, 1'b0);
    check("s6_an0",  32'(an),  32'h0000_00FE);
    check("s6_cat0", 32'(cat), 32'h0000_0019);
    for (int i = 1; i < 8; i++) begin
      tick(1'b0, 4'h0, 1'b1);
      check("s6_an_blank", 32'(an), 32'h0000_00FF);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        tick(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        check_disp("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lr3.md
LR3 -- requirements
Module: lr3

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter NUM_DIGITS, default 8: number of stored and displayed hex digits (fixed at 8 for this block).
REQ-003 Port CLK, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-004 Port RST, input, 1 bit: asynchronous active-low reset.
REQ-005 Port BTN_CE, input, 1 bit: synchronous one-cycle strobe from the external button debouncer that commits DAT_I.
REQ-006 Port DAT_I, input, 4 bits: hex digit to be entered.
REQ-007 Port DISP_CE, input, 1 bit: synchronous one-cycle strobe that advances the display scan.
REQ-008 Port CAT, output, 7 bits: seven-segment cathodes, active-low, CAT[0]=a through CAT[6]=g.
REQ-009 Port AN, output, 8 bits: digit anodes, active-low, AN[i] selects display position i.

Function
REQ-010 The block SHALL hold an 8-entry shift register of 4-bit digits, D0 (newest) to D7 (oldest).
REQ-011 On a rising CLK edge with BTN_CE=1, D0 SHALL load DAT_I and Dk SHALL load Dk-1 for k=1..7; D7's old value is discarded.
REQ-012 With BTN_CE=0, the shift register SHALL hold its contents.
REQ-013 The block SHALL keep a fill count FC (0..8), incremented on each BTN_CE and saturating at 8.
REQ-014 Position i SHALL be valid when i < FC.
REQ-015 The block SHALL keep a 3-bit scan index S, incremented modulo 8 on each rising edge with DISP_CE=1 (wraps from 7 to 0).
REQ-016 When position S is valid, AN SHALL equal the bitwise inverse of (1 << S), and CAT SHALL show the hex glyph of D[S].
REQ-017 When position S is invalid, AN SHALL be 8'hFF and CAT SHALL be 7'h7F.
REQ-018 Glyphs (CAT hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-019 CAT and AN SHALL be combinational functions of registered state (S, FC, D); they change in the same cycle that state changes.
REQ-020 If BTN_CE and DISP_CE are high in the same cycle, both actions SHALL take effect in that edge, independently.
REQ-021 BTN_CE held high for N cycles SHALL perform N shifts; no edge detection is done internally.

Reset
REQ-022 While RST=0, D0..D7 SHALL be 0, FC SHALL be 0, S SHALL be 0, AN SHALL be 8'hFF and CAT SHALL be 7'h7F, regardless of CLK.
REQ-023 Reset asserted mid-operation SHALL clear all state immediately; entry resumes at D0 with FC=0 after release.

Structure
REQ-024 A shared package SHALL hold NUM_DIGITS, the 16-entry glyph table, and the blank constants CAT_OFF=7'h7F and AN_OFF=8'hFF.
REQ-025 The glyph decode SHALL be one sub-module, hex7seg (4-bit in, 7-bit active-low CAT out); everything else stays in lr3.

Verification
REQ-026 Scenario 1 -- reset: pulse RST low. Required: AN=FF and CAT=7F; scanning with DISP_CE keeps AN=FF.
REQ-027 Scenario 2 -- single entry: enter DAT_I=2 with one BTN_CE, then scan. Required: at S=0, AN=FE and CAT=24; at S=1..7, AN=FF.
REQ-028 Scenario 3 -- two entries: enter 2 then 3. Required: at S=0, CAT=30 (3); at S=1, AN=FD and CAT=24 (2).
REQ-029 Scenario 4 -- overflow: enter 2,3,8,0,3,B,A,D,9,F. Required: FC=8; D0..D7 = F,9,D,A,B,3,0,8 (the oldest 2 and 3 are lost); at S=7, AN=7F and CAT=00.
REQ-030 Scenario 5 -- scan wrap and simultaneity:
- 8 DISP_CE pulses SHALL return S to 0.
- BTN_CE and DISP_CE in the same cycle SHALL both shift and advance S.
REQ-031 Scenario 6 -- mid-run reset: after 5 entries, drop RST asynchronously between clock edges. Required: AN=FF immediately; the next entry of 4 SHALL show CAT=19 at S=0 only.
